// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the lab5 multicycle main control unit
//               and the ALU control decoder: state encodings, opcodes,
//               alu_op codes, alu_src_b / pc_source encodings, and the
//               registered control-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // 4-bit state encodings; these values are visible on state_dbg.
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    // Instruction classes produced by the opcode decoder.
    typedef enum logic [2:0] {
        CLS_MEM = 3'd0,
        CLS_R   = 3'd1,
        CLS_I   = 3'd2,
        CLS_BR  = 3'd3,
        CLS_JMP = 3'd4,
        CLS_ILL = 3'd5
    } iclass_t;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_xori  = 6'b001110;
    localparam logic [5:0] c_op_bgt   = 6'b000111;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // alu_op codes shared with the ALU control decoder.
    localparam logic [2:0] c_alu_add   = 3'b000;
    localparam logic [2:0] c_alu_sub   = 3'b001;
    localparam logic [2:0] c_alu_rtype = 3'b010;
    localparam logic [2:0] c_alu_and   = 3'b011;
    localparam logic [2:0] c_alu_xor   = 3'b100;
    localparam logic [2:0] c_alu_or    = 3'b101;

    // ALU B-operand select.
    localparam logic [1:0] c_srcb_rb     = 2'b00;
    localparam logic [1:0] c_srcb_four   = 2'b01;
    localparam logic [1:0] c_srcb_imm    = 2'b10;
    localparam logic [1:0] c_srcb_imm_sh = 2'b11;

    // PC source select.
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // State-decoded (Moore) part of the control word.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic       imm_zext;
        logic       trap;
        logic [2:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
    } ctrl_out_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_opcode_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_opcode_decode
// Description : Combinational opcode lookup. Classifies the instruction and
//               supplies the immediate-op alu_op / zero-extend control.
//               Opcode 000010 is recognised as a jump only when
//               MAIN_CTRL_JUMP_EN is defined; otherwise it is illegal.
// Ports       : i_opcode       - IR[31:26]
//               o_iclass       - instruction class
//               o_is_load      - 1 for lw (vs sw) within CLS_MEM
//               o_imm_alu_op   - alu_op for I-type execute
//               o_imm_zext     - zero-extend immediate (andi/ori/xori)
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_opcode_decode
    import ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  logic [OPW-1:0] i_opcode,
    output iclass_t        o_iclass,
    output logic           o_is_load,
    output logic [2:0]     o_imm_alu_op,
    output logic           o_imm_zext
);

    always_comb begin
        o_iclass     = CLS_ILL;
        o_is_load    = 1'b0;
        o_imm_alu_op = c_alu_add;
        o_imm_zext   = 1'b0;
        case (i_opcode)
            c_op_rtype: o_iclass = CLS_R;
            c_op_lw: begin
                o_iclass  = CLS_MEM;
                o_is_load = 1'b1;
            end
            c_op_sw:    o_iclass = CLS_MEM;
            c_op_addi:  o_iclass = CLS_I;
            c_op_andi: begin
                o_iclass     = CLS_I;
                o_imm_alu_op = c_alu_and;
                o_imm_zext   = 1'b1;
            end
            c_op_ori: begin
                o_iclass     = CLS_I;
                o_imm_alu_op = c_alu_or;
                o_imm_zext   = 1'b1;
            end
            c_op_xori: begin
                o_iclass     = CLS_I;
                o_imm_alu_op = c_alu_xor;
                o_imm_zext   = 1'b1;
            end
            c_op_bgt:   o_iclass = CLS_BR;
`ifdef MAIN_CTRL_JUMP_EN
            c_op_j:     o_iclass = CLS_JMP;
`endif
            default:    o_iclass = CLS_ILL;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm
// Description : Multicycle main control unit for the lab5 processor.
//               Sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath enables
//               and mux selects, and produces alu_op for the ALU control
//               decoder. Memory accesses wait on mem_ready.
//               Optional feature macro: MAIN_CTRL_JUMP_EN (JUMP state and
//               opcode 000010); undefined, 000010 traps.
// Ports       : clk, rst_n (async, active-low)
//               opcode, mem_ready               - inputs
//               alu_op, alu_src_b, pc_source    - datapath selects
//               pc_write, pc_write_cond, ir_write, mem_read, mem_write,
//               reg_write, iord, reg_dst, mem_to_reg, alu_src_a, imm_zext
//               trap      - sticky illegal-opcode flag
//               state_dbg - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int AOPW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    output logic [AOPW-1:0] alu_op,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            ir_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            reg_write,
    output logic            iord,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic            imm_zext,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_source,
    output logic            trap,
    output logic [3:0]      state_dbg
);

    state_t    r_state;
    state_t    w_next;
    logic      r_armed;
    ctrl_out_t r_out;
    ctrl_out_t w_out;

    iclass_t    w_iclass;
    logic       w_is_load;
    logic [2:0] w_imm_alu_op;
    logic       w_imm_zext;
    logic       w_fetch_done;

    ctrl_opcode_decode #(
        .OPW (OPW)
    ) u_opcode_decode (
        .i_opcode     (opcode),
        .o_iclass     (w_iclass),
        .o_is_load    (w_is_load),
        .o_imm_alu_op (w_imm_alu_op),
        .o_imm_zext   (w_imm_zext)
    );

    // Control word for a given state. Evaluated for the next state so the
    // outputs come straight from flops once that state is entered.
    function automatic ctrl_out_t state_outputs(input state_t s,
                                                input logic [2:0] imm_op,
                                                input logic zext);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_FETCH: begin
                o.mem_read  = 1'b1;
                o.alu_src_b = c_srcb_four;
                o.alu_op    = c_alu_add;
                o.pc_source = c_pcsrc_alu;
            end
            S_DECODE: begin
                // Branch target into ALUOut ahead of knowing the class.
                o.alu_src_b = c_srcb_imm_sh;
                o.alu_op    = c_alu_add;
            end
            S_MEM_ADDR: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = c_srcb_imm;
                o.alu_op    = c_alu_add;
            end
            S_MEM_READ: begin
                o.mem_read = 1'b1;
                o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                o.reg_write  = 1'b1;
                o.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o.mem_write = 1'b1;
                o.iord      = 1'b1;
            end
            S_R_EXEC: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = c_srcb_rb;
                o.alu_op    = c_alu_rtype;
            end
            S_R_WB: begin
                o.reg_write = 1'b1;
                o.reg_dst   = 1'b1;
            end
            S_I_EXEC: begin
                o.alu_src_a = 1'b1;
                o.alu_src_b = c_srcb_imm;
                o.alu_op    = imm_op;
                o.imm_zext  = zext;
            end
            S_I_WB: begin
                o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                // Datapath qualifies pc_write_cond with its gt flag.
                o.alu_src_a     = 1'b1;
                o.alu_src_b     = c_srcb_rb;
                o.alu_op        = c_alu_sub;
                o.pc_write_cond = 1'b1;
                o.pc_source     = c_pcsrc_aluout;
            end
`ifdef MAIN_CTRL_JUMP_EN
            S_JUMP: begin
                o.pc_write  = 1'b1;
                o.pc_source = c_pcsrc_jump;
            end
`endif
            S_TRAP: begin
                o.trap = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            // r_armed delays the first FETCH to the second edge after reset.
            S_IDLE:      if (r_armed) w_next = S_FETCH;
            S_FETCH:     if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_iclass)
                    CLS_MEM: w_next = S_MEM_ADDR;
                    CLS_R:   w_next = S_R_EXEC;
                    CLS_I:   w_next = S_I_EXEC;
                    CLS_BR:  w_next = S_BRANCH;
`ifdef MAIN_CTRL_JUMP_EN
                    CLS_JMP: w_next = S_JUMP;
`endif
                    default: w_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  w_next = w_is_load ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
            S_MEM_WB:    w_next = S_FETCH;
            S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
            S_R_EXEC:    w_next = S_R_WB;
            S_R_WB:      w_next = S_FETCH;
            S_I_EXEC:    w_next = S_I_WB;
            S_I_WB:      w_next = S_FETCH;
            S_BRANCH:    w_next = S_FETCH;
`ifdef MAIN_CTRL_JUMP_EN
            S_JUMP:      w_next = S_FETCH;
`endif
            S_TRAP:      w_next = S_TRAP;
            default:     w_next = S_TRAP;
        endcase
    end

    always_comb begin
        w_out = state_outputs(w_next, w_imm_alu_op, w_imm_zext);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= 1'b1;
            r_out   <= w_out;
        end
    end

    // Only Mealy terms: IR load and PC+4 write on the fetch handshake.
    assign w_fetch_done  = (r_state == S_FETCH) && mem_ready;

    assign ir_write      = w_fetch_done;
    assign pc_write      = r_out.pc_write | w_fetch_done;
    assign pc_write_cond = r_out.pc_write_cond;
    assign mem_read      = r_out.mem_read;
    assign mem_write     = r_out.mem_write;
    assign reg_write     = r_out.reg_write;
    assign iord          = r_out.iord;
    assign reg_dst       = r_out.reg_dst;
    assign mem_to_reg    = r_out.mem_to_reg;
    assign alu_src_a     = r_out.alu_src_a;
    assign imm_zext      = r_out.imm_zext;
    assign trap          = r_out.trap;
    assign alu_op        = AOPW'(r_out.alu_op);
    assign alu_src_b     = r_out.alu_src_b;
    assign pc_source     = r_out.pc_source;
    assign state_dbg     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_control_fsm
// Description : Self-checking bench for main_control_fsm. A sequence-table
//               model predicts every output each cycle; directed runs pin
//               cycle counts and key output values; a randomized phase
//               exercises stalls, opcodes and resets.
//               Honours MAIN_CTRL_JUMP_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_control_fsm;
    import ctrl_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
    logic       reg_write, iord, reg_dst, mem_to_reg, alu_src_a, imm_zext;
    logic [1:0] alu_src_b, pc_source;
    logic       trap;
    logic [3:0] state_dbg;

    main_control_fsm #(.OPW(6), .AOPW(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_op        (alu_op),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .iord          (iord),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .imm_zext      (imm_zext),
        .alu_src_b     (alu_src_b),
        .pc_source     (pc_source),
        .trap          (trap),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    typedef struct packed {
        logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write;
        logic       reg_write, iord, reg_dst, mem_to_reg, alu_src_a, imm_zext, trap;
        logic [2:0] alu_op;
        logic [1:0] alu_src_b, pc_source;
        logic [3:0] st;
    } obs_t;

    logic [18:0] all_out;
    assign all_out = {pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                      reg_write, iord, reg_dst, mem_to_reg, alu_src_a, imm_zext,
                      trap, alu_op, alu_src_b, pc_source};

    // ------------------------------------------------------------------
    // Model: instruction = fixed phase list chosen by opcode; memory
    // phases repeat while mem_ready is low.
    // ------------------------------------------------------------------
    state_t     m_phase;
    logic       m_armed;
    logic [5:0] m_op;
    int         m_step;

    function automatic state_t seq_at(input logic [5:0] op, input int k);
        state_t l[4];
        int n;
        l[0] = S_DECODE; l[1] = S_TRAP; l[2] = S_FETCH; l[3] = S_FETCH;
        n = 2;
        case (op)
            6'b100011: begin l[1] = S_MEM_ADDR; l[2] = S_MEM_READ; l[3] = S_MEM_WB; n = 4; end
            6'b101011: begin l[1] = S_MEM_ADDR; l[2] = S_MEM_WRITE; n = 3; end
            6'b000000: begin l[1] = S_R_EXEC; l[2] = S_R_WB; n = 3; end
            6'b001000, 6'b001100, 6'b001101, 6'b001110:
                       begin l[1] = S_I_EXEC; l[2] = S_I_WB; n = 3; end
            6'b000111: l[1] = S_BRANCH;
`ifdef MAIN_CTRL_JUMP_EN
            6'b000010: l[1] = S_JUMP;
`endif
            default:   l[1] = S_TRAP;
        endcase
        return (k < n) ? l[k] : S_FETCH;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= S_IDLE;
            m_armed <= 1'b0;
            m_step  <= 0;
            m_op    <= 6'd0;
        end else begin
            case (m_phase)
                S_IDLE:  if (m_armed) m_phase <= S_FETCH; else m_armed <= 1'b1;
                S_FETCH: if (mem_ready) begin
                    m_op    <= opcode;
                    m_step  <= 0;
                    m_phase <= seq_at(opcode, 0);
                end
                S_TRAP:  m_phase <= S_TRAP;
                default: if (!((m_phase == S_MEM_READ || m_phase == S_MEM_WRITE) && !mem_ready)) begin
                    m_step  <= m_step + 1;
                    m_phase <= seq_at(m_op, m_step + 1);
                end
            endcase
        end
    end

    function automatic obs_t exp_obs(input state_t ph, input logic [5:0] op, input logic mr);
        obs_t e;
        e = '0;
        e.st = ph;
        case (ph)
            S_FETCH:     begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
            S_DECODE:    e.alu_src_b = 2'b11;
            S_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            S_MEM_READ:  begin e.mem_read = 1; e.iord = 1; end
            S_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
            S_MEM_WRITE: begin e.mem_write = 1; e.iord = 1; end
            S_R_EXEC:    begin e.alu_src_a = 1; e.alu_op = 3'b010; end
            S_R_WB:      begin e.reg_write = 1; e.reg_dst = 1; end
            S_I_EXEC: begin
                e.alu_src_a = 1; e.alu_src_b = 2'b10;
                case (op)
                    6'b001100: begin e.alu_op = 3'b011; e.imm_zext = 1; end
                    6'b001110: begin e.alu_op = 3'b100; e.imm_zext = 1; end
                    6'b001101: begin e.alu_op = 3'b101; e.imm_zext = 1; end
                    default:   e.alu_op = 3'b000;
                endcase
            end
            S_I_WB:      e.reg_write = 1;
            S_BRANCH:    begin e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            S_JUMP:      begin e.pc_write = 1; e.pc_source = 2'b10; end
            S_TRAP:      e.trap = 1;
            default:     e = e;
        endcase
        return e;
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            obs_t a, e;
            a = {all_out, state_dbg};
            e = exp_obs(m_phase, m_op, mem_ready);
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle_model t=%0t phase=%0d actual=%h required=%h", $time, m_phase, a, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Starts with model in FETCH just after an edge; returns when back in
    // FETCH (or TRAP). rd_stalls low cycles of mem_ready in the memory phase.
    task automatic run_instr(input logic [5:0] op, input int rd_stalls,
                             input int req_cycles, input string name);
        int cyc;
        int stalls;
        cyc = 0;
        stalls = rd_stalls;
        opcode = op;
        mem_ready = 1'b1;
        do begin
            @(posedge clk); #1;
            cyc++;
            if ((m_phase == S_MEM_READ || m_phase == S_MEM_WRITE) && stalls > 0) begin
                mem_ready = 1'b0;
                stalls--;
            end else begin
                mem_ready = 1'b1;
            end
            case (m_phase)
                S_MEM_ADDR: chk({name, "_addr_aluop"}, 32'(alu_op), 32'h0);
                S_R_EXEC:   chk({name, "_rexec"}, 32'({alu_op, alu_src_b}), 32'b010_00);
                S_R_WB:     chk({name, "_rwb_regdst"}, 32'(reg_dst), 32'h1);
                S_I_EXEC:   if (op == 6'b001110)
                                chk({name, "_iexec_xori"}, 32'({alu_op, imm_zext, alu_src_b}), 32'b100_1_10);
                S_BRANCH:   chk({name, "_branch"}, 32'({alu_op, pc_write_cond, pc_source, pc_write}), 32'b001_1_01_0);
                S_JUMP:     chk({name, "_jump_pcsrc"}, 32'(pc_source), 32'h2);
                default: ;
            endcase
        end while (m_phase != S_FETCH && m_phase != S_TRAP && cyc < 40);
        chk({name, "_cycles"}, 32'(cyc), 32'(req_cycles));
    endtask

    task automatic reset_to_fetch();
        int n;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b1;
        n = 0;
        while (m_phase != S_FETCH && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_to_fetch_bound", 32'(m_phase == S_FETCH), 32'h1);
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] ops [9];
        int r;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b001000; ops[4] = 6'b001100; ops[5] = 6'b001101;
        ops[6] = 6'b001110; ops[7] = 6'b000111; ops[8] = 6'b000010;
        r = $urandom_range(0, 39);
        if (r < 36) return ops[r % 9];
        return 6'($urandom_range(0, 63));
    endfunction

    initial begin
        int trap_cnt;
        int hold;
        rst_n = 1'b0;
        opcode = 6'd0;
        mem_ready = 1'b0;
        #2 chk_en = 1'b1;

        // Reset: held 3 cycles, released with mem_ready=1.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", 32'(all_out), 32'h0);
        chk("reset_state_idle", 32'(state_dbg), 32'h0);
        mem_ready = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_reset_idle_outputs", 32'(all_out), 32'h0);
        chk("post_reset_idle_state", 32'(state_dbg), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("first_fetch", 32'({state_dbg, mem_read, ir_write, pc_write}), 32'b0001_1_1_1);
        @(posedge clk); #1;
        // That edge completed the fetch; restart cleanly in FETCH.
        reset_to_fetch();

        run_instr(6'b100011, 0, 5, "lw");
        run_instr(6'b101011, 0, 4, "sw");
        run_instr(6'b000000, 0, 4, "rtype");
        run_instr(6'b001110, 0, 4, "xori");
        run_instr(6'b000111, 0, 3, "bgt");
        run_instr(6'b100011, 2, 7, "lw_wait");
        run_instr(6'b101011, 3, 7, "sw_wait");
        run_instr(6'b001100, 0, 4, "andi");
        run_instr(6'b001101, 0, 4, "ori");
        run_instr(6'b001000, 0, 4, "addi");

`ifdef MAIN_CTRL_JUMP_EN
        run_instr(6'b000010, 0, 3, "jump");
`else
        run_instr(6'b000010, 0, 2, "jump_traps");
        chk("jump_traps_flag", 32'(trap), 32'h1);
        reset_to_fetch();
`endif

        // Illegal opcode: trap from the cycle after DECODE, sticky.
        run_instr(6'b111111, 0, 2, "illegal");
        chk("illegal_trap", 32'(trap), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("illegal_trap_sticky", 32'({trap, state_dbg}), 32'h1D);
        rst_n = 1'b0;
        #1;
        chk("trap_cleared_by_reset", 32'({trap, state_dbg}), 32'h0);
        #1;
        reset_to_fetch();

        // Reset mid-store: mem_write must drop without a clock edge.
        opcode = 6'b101011;
        mem_ready = 1'b1;
        hold = 0;
        do begin
            @(posedge clk); #1;
            hold++;
        end while (m_phase != S_MEM_WRITE && hold < 10);
        mem_ready = 1'b0;
        #2;
        chk("sw_mem_write_high", 32'(mem_write), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("sw_reset_mem_write_async", 32'(mem_write), 32'h0);
        chk("sw_reset_all_zero", 32'(all_out), 32'h0);
        #1;
        reset_to_fetch();

        // Randomized traffic with stalls and occasional resets.
        trap_cnt = 0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!rst_n) begin
                if (hold > 0) hold--;
                else rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0 || trap_cnt > 4) begin
                rst_n = 1'b0;
                hold = $urandom_range(0, 2);
                trap_cnt = 0;
            end
            if (m_phase == S_TRAP) trap_cnt++;
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_phase == S_FETCH) opcode = pick_op();
        end

        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
